// File: rtl/bcd_multi_accumulator_if.sv
// Handshake bundle for bcd_multi_accumulator.
//   in_valid / in_ready / in_num        : operand input (BCD, digit 0 in [3:0])
//   out_valid / out_ready / out_sum     : result output (BCD, DIGITS+2 digits)
//   bcd_err                             : non-BCD digit seen in current batch
// Modports: slave = accumulator side, master = producer/consumer side.
interface bcd_multi_accumulator_if #(
    parameter int unsigned DIGITS = 2
);
    logic                      in_valid;
    logic                      in_ready;
    logic [4*DIGITS-1:0]       in_num;
    logic                      out_valid;
    logic                      out_ready;
    logic [4*(DIGITS+2)-1:0]   out_sum;
    logic                      bcd_err;

    modport master (
        output in_valid, in_num, out_ready,
        input  in_ready, out_valid, out_sum, bcd_err
    );

    modport slave (
        input  in_valid, in_num, out_ready,
        output in_ready, out_valid, out_sum, bcd_err
    );
endinterface

// File: rtl/bcd_multi_accumulator.sv
// Digit-serial BCD accumulator: sums OPS operands of DIGITS BCD digits each,
// one operand per valid/ready transfer, one BCD digit per clock.
// Ports:
//   clock  : system clock, all state on posedge
//   reset  : asynchronous, active-high
//   bus    : bcd_multi_accumulator_if.slave (in_valid/in_ready/in_num,
//            out_valid/out_ready/out_sum, bcd_err)
// Optional feature: define BCD_MULTI_ACC_CHECK_EN to flag operands holding a
// digit >9 (sticky until the result is taken). Undefined: bcd_err tied 0.
module bcd_multi_accumulator #(
    parameter int unsigned DIGITS = 2,
    parameter int unsigned OPS    = 3
) (
    input  logic                    clock,
    input  logic                    reset,
    bcd_multi_accumulator_if.slave  bus
);
    localparam int unsigned NDIG = DIGITS + 2;
    localparam int unsigned W    = 4 * NDIG;
    localparam int unsigned KW   = $clog2(NDIG);
    localparam int unsigned CW   = $clog2(OPS + 1);

    typedef enum logic [1:0] {
        LOAD,
        ADD,
        DONE
    } state_t;

    state_t          state_q, state_d;
    logic [W-1:0]    acc_q, acc_d;
    logic [W-1:0]    op_q, op_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [KW-1:0]   k_q, k_d;
    logic            carry_q, carry_d;

    logic [3:0]      acc_dig;
    logic [3:0]      op_dig;
    logic [4:0]      sum5;
    logic [3:0]      dig_new;
    logic            carry_new;

`ifdef BCD_MULTI_ACC_CHECK_EN
    logic            err_q, err_d;
    logic            in_bad;

    always_comb begin
        in_bad = 1'b0;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (bus.in_num[4*i +: 4] > 4'd9) in_bad = 1'b1;
        end
    end

    assign bus.bcd_err = err_q;
`else
    assign bus.bcd_err = 1'b0;
`endif

    assign bus.in_ready  = (state_q == LOAD);
    assign bus.out_valid = (state_q == DONE);
    assign bus.out_sum   = acc_q;

    // Current digit pair selected by a compare-mux rather than a variable
    // part-select, so k never indexes past the operand width.
    always_comb begin
        acc_dig = '0;
        op_dig  = '0;
        for (int unsigned i = 0; i < NDIG; i++) begin
            if (k_q == KW'(i)) begin
                acc_dig = acc_q[4*i +: 4];
                op_dig  = op_q[4*i +: 4];
            end
        end
        sum5 = {1'b0, acc_dig} + {1'b0, op_dig} + {4'b0000, carry_q};
        if (sum5 >= 5'd10) begin
            dig_new   = 4'(sum5 - 5'd10);
            carry_new = 1'b1;
        end else begin
            dig_new   = sum5[3:0];
            carry_new = 1'b0;
        end
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        op_d    = op_q;
        cnt_d   = cnt_q;
        k_d     = k_q;
        carry_d = carry_q;
`ifdef BCD_MULTI_ACC_CHECK_EN
        err_d   = err_q;
`endif
        unique case (state_q)
            LOAD: begin
                if (bus.in_valid) begin
                    op_d    = W'(bus.in_num);
                    cnt_d   = cnt_q + 1'b1;
                    k_d     = '0;
                    carry_d = 1'b0;
                    state_d = ADD;
`ifdef BCD_MULTI_ACC_CHECK_EN
                    err_d   = err_q | in_bad;
`endif
                end
            end
            ADD: begin
                for (int unsigned i = 0; i < NDIG; i++) begin
                    if (k_q == KW'(i)) acc_d[4*i +: 4] = dig_new;
                end
                carry_d = carry_new;
                if (k_q == KW'(NDIG - 1)) begin
                    k_d     = '0;
                    state_d = (cnt_q == CW'(OPS)) ? DONE : LOAD;
                end else begin
                    k_d = k_q + 1'b1;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = LOAD;
`ifdef BCD_MULTI_ACC_CHECK_EN
                    err_d   = 1'b0;
`endif
                end
            end
            default: state_d = LOAD;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= LOAD;
            acc_q   <= '0;
            op_q    <= '0;
            cnt_q   <= '0;
            k_q     <= '0;
            carry_q <= 1'b0;
`ifdef BCD_MULTI_ACC_CHECK_EN
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
            k_q     <= k_d;
            carry_q <= carry_d;
`ifdef BCD_MULTI_ACC_CHECK_EN
            err_q   <= err_d;
`endif
        end
    end
endmodule

// File: tb/tb_bcd_multi_accumulator.sv
// Directed bench for bcd_multi_accumulator: a DIGITS=2/OPS=3 instance and a
// DIGITS=1/OPS=99 instance. Inputs driven and outputs sampled on negedge.
module tb_bcd_multi_accumulator;
    logic clock = 1'b0;
    logic reset;

    always #5 clock = ~clock;

`ifdef BCD_MULTI_ACC_CHECK_EN
    localparam logic EXP_ERR = 1'b1;
`else
    localparam logic EXP_ERR = 1'b0;
`endif

    bcd_multi_accumulator_if #(.DIGITS(2)) bi ();
    bcd_multi_accumulator_if #(.DIGITS(1)) bj ();

    bcd_multi_accumulator #(.DIGITS(2), .OPS(3)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bi)
    );

    bcd_multi_accumulator #(.DIGITS(1), .OPS(99)) dut99 (
        .clock (clock),
        .reset (reset),
        .bus   (bj)
    );

    int n_assert = 0;
    int n_fail   = 0;
    int xfer_a   = 0;
    int xfer_b   = 0;

    always @(posedge clock) begin
        if (bi.in_valid && bi.in_ready) xfer_a++;
        if (bj.in_valid && bj.in_ready) xfer_b++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Starts and ends just after a negedge. Checks in_ready stays low for
    // exactly 4 cycles after the transfer.
    task automatic send_a(input logic [7:0] v, input bit last);
        int n;
        n = 0;
        bi.in_valid = 1'b1;
        bi.in_num   = v;
        while (!bi.in_ready && n < 100) begin
            @(negedge clock);
            n++;
        end
        check("send_ready_timeout", 32'(n < 100), 32'd1);
        @(posedge clock);
        @(negedge clock);
        bi.in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("busy_in_ready", 32'(bi.in_ready), 32'd0);
            @(negedge clock);
        end
        if (last) check("out_valid_latency", 32'(bi.out_valid), 32'd1);
        else      check("ready_again", 32'(bi.in_ready), 32'd1);
    endtask

    task automatic wait_done_a();
        int n;
        n = 0;
        while (!bi.out_valid && n < 200) begin
            @(negedge clock);
            n++;
        end
        check("done_timeout", 32'(n < 200), 32'd1);
    endtask

    task automatic take_a(input logic [15:0] exp, input string tag);
        wait_done_a();
        check(tag, 32'(bi.out_sum), 32'(exp));
        bi.out_ready = 1'b1;
        @(posedge clock);
        @(negedge clock);
        bi.out_ready = 1'b0;
        check("take_out_valid", 32'(bi.out_valid), 32'd0);
        check("take_in_ready", 32'(bi.in_ready), 32'd1);
        check("take_sum_clear", 32'(bi.out_sum), 32'd0);
        check("take_err_clear", 32'(bi.bcd_err), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        reset        = 1'b1;
        bi.in_valid  = 1'b0;
        bi.in_num    = '0;
        bi.out_ready = 1'b0;
        bj.in_valid  = 1'b0;
        bj.in_num    = '0;
        bj.out_ready = 1'b0;
        repeat (2) @(negedge clock);

        // Reset state
        check("rst_in_ready", 32'(bi.in_ready), 32'd1);
        check("rst_out_valid", 32'(bi.out_valid), 32'd0);
        check("rst_out_sum", 32'(bi.out_sum), 32'd0);
        check("rst_bcd_err", 32'(bi.bcd_err), 32'd0);
        check("rst99_in_ready", 32'(bj.in_ready), 32'd1);
        check("rst99_out_sum", 32'(bj.out_sum), 32'd0);
        reset = 1'b0;
        @(negedge clock);

        // 1: 45+38+17 = 100
        send_a(8'h45, 1'b0);
        send_a(8'h38, 1'b0);
        send_a(8'h17, 1'b1);
        take_a(16'h0100, "t1_sum");

        // 2: 99*3 = 297
        send_a(8'h99, 1'b0);
        send_a(8'h99, 1'b0);
        send_a(8'h99, 1'b1);
        take_a(16'h0297, "t2_sum");

        // 2b: DIGITS=1, OPS=99, 99 x 9 = 891
        xfer_b = 0;
        bj.in_valid = 1'b1;
        bj.in_num   = 4'h9;
        n = 0;
        while (!bj.out_valid && n < 1000) begin
            @(negedge clock);
            n++;
        end
        bj.in_valid = 1'b0;
        check("t2b_timeout", 32'(n < 1000), 32'd1);
        check("t2b_xfers", 32'(xfer_b), 32'd99);
        check("t2b_sum", 32'(bj.out_sum), 32'h891);
        bj.out_ready = 1'b1;
        @(posedge clock);
        @(negedge clock);
        bj.out_ready = 1'b0;
        check("t2b_take_valid", 32'(bj.out_valid), 32'd0);
        check("t2b_take_ready", 32'(bj.in_ready), 32'd1);

        // 3: result held while out_ready low; next batch starts from zero
        send_a(8'h10, 1'b0);
        send_a(8'h20, 1'b0);
        send_a(8'h30, 1'b1);
        for (int i = 0; i < 5; i++) begin
            check("t3_hold_valid", 32'(bi.out_valid), 32'd1);
            check("t3_hold_sum", 32'(bi.out_sum), 32'h0060);
            check("t3_hold_ready", 32'(bi.in_ready), 32'd0);
            @(negedge clock);
        end
        take_a(16'h0060, "t3_sum_a");
        send_a(8'h01, 1'b0);
        send_a(8'h02, 1'b0);
        send_a(8'h03, 1'b1);
        take_a(16'h0006, "t3_sum_b");

        // 4: in_valid held high with 12 throughout; only LOAD consumes it
        xfer_a = 0;
        bi.in_valid = 1'b1;
        bi.in_num   = 8'h12;
        wait_done_a();
        repeat (3) @(negedge clock);
        bi.in_valid = 1'b0;
        check("t4_xfers", 32'(xfer_a), 32'd3);
        take_a(16'h0036, "t4_sum");

        // 5: reset during the second operand's ADD
        send_a(8'h50, 1'b0);
        bi.in_valid = 1'b1;
        bi.in_num   = 8'h60;
        @(posedge clock);
        @(negedge clock);
        bi.in_valid = 1'b0;
        @(negedge clock);
        check("t5_mid_add", 32'(bi.in_ready), 32'd0);
        reset = 1'b1;
        #1;
        check("t5_rst_valid", 32'(bi.out_valid), 32'd0);
        check("t5_rst_ready", 32'(bi.in_ready), 32'd1);
        check("t5_rst_sum", 32'(bi.out_sum), 32'd0);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        send_a(8'h05, 1'b0);
        send_a(8'h05, 1'b0);
        send_a(8'h05, 1'b1);
        take_a(16'h0015, "t5_sum");

        // 6: non-BCD digit: 1A -> digit0 10 -> 0 carry 1, digit1 1+1 = 2
        send_a(8'h1A, 1'b0);
        send_a(8'h00, 1'b0);
        send_a(8'h00, 1'b1);
        check("t6_bcd_err", 32'(bi.bcd_err), 32'(EXP_ERR));
        take_a(16'h0020, "t6_sum");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
